// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian 32-bit words from a byte stream and writes them into instruction RAM.
// Latency: 5 cycles per word (4 byte-accept cycles + 1 write cycle); N==0 loads finish one cycle after start.
// Backpressure: byte_ready is high only in RECV; an offered byte is held by the source until accepted.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_N = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   ONE_N   = 1;
    localparam logic [ADDR_W-1:0] ONE_IDX = 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       acc_q, acc_d;       // first three bytes of the word in flight
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wd_q, imem_wd_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic [ADDR_W:0]   start_n;

    // byte_ready is a pure decode of the state register so the source sees it in the same cycle
    assign byte_ready = (state_q == S_RECV);
    assign accept     = byte_valid && byte_ready;
    assign start_n    = (word_count > DEPTH_N) ? DEPTH_N : word_count;

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wd    = imem_wd_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state logic; registered outputs are decoded from the next state so they line up with state_q
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        imem_addr_d = imem_addr_q;
        imem_wd_d   = imem_wd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d     = start_n;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (start_n == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    acc_d = {acc_q[15:0], byte_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        imem_addr_d = idx_q;
                        imem_wd_d   = {acc_q, byte_data};
                    end
                end
            end
            S_WRITE: begin
                if ({1'b0, idx_q} == n_q - ONE_N) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ONE_IDX;
                    cnt_d   = '0;
                    state_d = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        imem_we_d   = (state_d == S_WRITE);
        busy_d      = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        cpu_reset_d = (state_d != S_DONE);
    end

    // State and output registers; reset drops straight back to IDLE, abandoning any partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_wd_q   <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_wd_q   <= imem_wd_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
